hwpf_req_queue: RTL and testbench
=================================

// Module: hwpf_req_queue
// PURPOSE
//  Prefetch-request queue for the next-line HW prefetcher; successor of hwpf_fifo.
//  Up to INSERTS candidate addresses per cycle are deduplicated against queued entries
//  and against each other, then stored in age order.
//  Adds a valid/ready issue port that drains the oldest entry to the memory side,
//  a selectable overflow policy, occupancy output and a saturating drop counter.
//  Sits between the prefetch address generator and the dcache/L2 request arbiter.
// PARAMETERS
//  ADDR_WIDTH   40  address width in bits (matches drac_pkg::addr_t)
//  QUEUE_DEPTH  4   number of entries; >= 2
//  INSERTS      2   insert ports per cycle; 1 <= INSERTS <= QUEUE_DEPTH
//  DROP_OLDEST  1   1: on overflow evict oldest entries; 0: discard excess new requests
//  CNT_WIDTH    16  width of drop counter
// PORTS
//  clk_i         in   1                    clock
//  rst_ni        in   1                    reset, synchronous, active-low
//  flush_i       in   1                    clear all entries
//  lock_i        in   1                    block insertion; issue port unaffected
//  take_req_i    in   [INSERTS]            per-port insert request
//  cpu_req_i     in   [INSERTS][ADDR_WIDTH]  per-port address
//  issue_valid_o out  1                    oldest entry available
//  issue_addr_o  out  ADDR_WIDTH           oldest entry address
//  issue_ready_i in   1                    downstream accepts the oldest entry
//  data_cpu_o    out  [QUEUE_DEPTH][ADDR_WIDTH]  contents in age order; [0] is oldest
//  data_valid_o  out  [QUEUE_DEPTH]        entry valid; valids always contiguous from [0]
//  count_o       out  $clog2(QUEUE_DEPTH+1)  number of valid entries
//  overflow_o    out  1                    1-cycle pulse; a request or entry was dropped
//  drop_cnt_o    out  CNT_WIDTH            saturating count of dropped requests and entries
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk edge): all valids 0, count 0, issue_valid_o 0,
//    overflow_o 0, drop_cnt_o 0. Reset in mid-operation discards everything.
//  - Storage: circular buffer with head pointer and count. Outputs are rotated so that
//    index 0 is the head. All outputs come from registers except issue_addr_o and
//    issue_valid_o, which are taken directly from head/count.
//  - issue_valid_o = (count != 0). Pop occurs when issue_valid_o & issue_ready_i; the
//    head entry leaves at the next edge. An entry popped this cycle still counts for dedup.
//  - Insert acceptance, port k, evaluated in ascending k:
//    take_req_i[k] & !lock_i & !flush_i & no valid entry == cpu_req_i[k] &
//    no lower accepted port j<k with an equal address.
//    Accepted ports append at the tail in port order, lowest port first.
//  - Space: free = QUEUE_DEPTH - count + pop. Let n = number of accepted ports.
//    If n > free, then excess = n - free:
//      DROP_OLDEST=1: evict the excess oldest surviving entries; all n are stored.
//      DROP_OLDEST=0: store only the first free accepted ports; the excess highest ports are lost.
//    overflow_o=1 in the next cycle; drop_cnt_o += excess, saturating at all-ones.
//    Dedup rejects are not counted.
//  - flush_i=1: at the next edge all valids clear and count=0. Flush overrides insert.
//    A pop handshake in the same cycle still counts as completed. drop_cnt_o is kept.
//    overflow_o is 0.
//  - Latency: an accepted insert is visible on data_*_o, count_o and issue_* one cycle later.
//  - Pointer wrap: head and tail are modulo QUEUE_DEPTH; a non-power-of-2 depth must work.
// TESTING (DEPTH=3, INSERTS=2, addresses shown as low hex digit of 0xCAFE000x)
//  1. Reset for 2 cycles -> data_valid_o all 0, count_o 0, issue_valid_o 0, drop_cnt_o 0.
//  2. lock=1, port0 inserts 0 -> nothing stored. lock=0, insert 0 -> count 1,
//     issue_addr_o 0xCAFE0000.
//  3. Queue {0}; both ports insert 1 -> count 2. Then ports insert {0,1} -> count stays 2,
//     overflow_o 0.
//  4. DROP_OLDEST=1, queue {0,1,2}, insert {3,4}, ready=0 -> {2,3,4}, overflow_o pulse,
//     drop_cnt 2. DROP_OLDEST=0 -> {0,1,2}, drop_cnt 2.
//  5. Queue {0,1,2}, issue_ready=1, port0 inserts 3 -> pops 0, result {1,2,3},
//     overflow_o 0, count 3.
//  6. Queue {1,2,3}, flush=1 with port0 inserting 5 -> empty next cycle, 5 absent,
//     drop_cnt_o unchanged; 6 pushes with depth wrap keep age order.

Source files
------------

// File: rtl/hwpf_req_queue_if.sv
// Bus bundle for hwpf_req_queue: insert ports, issue handshake and observation outputs.
// The slave modport is the queue side; the master modport is the producer/consumer side.
interface hwpf_req_queue_if #(
   parameter int ADDR_WIDTH  = 40,
   parameter int QUEUE_DEPTH = 4,
   parameter int INSERTS     = 2,
   parameter int CNT_WIDTH   = 16
);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   logic                                    flush_i;
   logic                                    lock_i;
   logic [INSERTS-1:0]                      take_req_i;
   logic [INSERTS-1:0][ADDR_WIDTH-1:0]      cpu_req_i;
   logic                                    issue_valid_o;
   logic [ADDR_WIDTH-1:0]                   issue_addr_o;
   logic                                    issue_ready_i;
   logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0]  data_cpu_o;
   logic [QUEUE_DEPTH-1:0]                  data_valid_o;
   logic [CW-1:0]                           count_o;
   logic                                    overflow_o;
   logic [CNT_WIDTH-1:0]                    drop_cnt_o;

   modport slave (
      input  flush_i, lock_i, take_req_i, cpu_req_i, issue_ready_i,
      output issue_valid_o, issue_addr_o, data_cpu_o, data_valid_o,
             count_o, overflow_o, drop_cnt_o
   );

   modport master (
      output flush_i, lock_i, take_req_i, cpu_req_i, issue_ready_i,
      input  issue_valid_o, issue_addr_o, data_cpu_o, data_valid_o,
             count_o, overflow_o, drop_cnt_o
   );
endinterface

// File: rtl/hwpf_req_queue.sv
// Deduplicating prefetch-request queue: circular buffer with multi-port insert,
// valid/ready issue of the oldest entry, overflow policy and saturating drop counter.
module hwpf_req_queue #(
   parameter int ADDR_WIDTH  = 40,
   parameter int QUEUE_DEPTH = 4,
   parameter int INSERTS     = 2,
   parameter int DROP_OLDEST = 1,
   parameter int CNT_WIDTH   = 16
) (
   input logic              clk_i,
   input logic              rst_ni,
   hwpf_req_queue_if.slave  bus
);
   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int DW = CNT_WIDTH + 1;

   logic [ADDR_WIDTH-1:0]                  mem_q [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]                  memD  [QUEUE_DEPTH];
   logic [PW-1:0]                          head_q, headD;
   logic [CW-1:0]                          count_q, countD;
   logic                                   overflow_q, overflowD;
   logic [CNT_WIDTH-1:0]                   dropCnt_q, dropCntD;
   logic [DW-1:0]                          dropSum;
   logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0] dataCpu_q, dataCpuD;
   logic [QUEUE_DEPTH-1:0]                 dataValid_q, dataValidD;
   logic [INSERTS-1:0]                     accepted;
   logic                                   pop;
   logic                                   dup;
   int                                     nAcc, cntAfterPop, freeSlots, excess, evict, stored, slot;

   function automatic logic [PW-1:0] wrapIdx(input int base, input int off);
      return PW'((base + off) % QUEUE_DEPTH);
   endfunction

   assign pop = (count_q != '0) & bus.issue_ready_i;

   // Dedup sees every valid entry, including one that leaves through the issue port this cycle.
   always_comb begin
      memD        = mem_q;
      accepted    = '0;
      nAcc        = 0;
      dup         = 1'b0;
      slot        = 0;
      headD       = head_q;
      countD      = count_q;
      overflowD   = 1'b0;
      dropCntD    = dropCnt_q;
      dropSum     = '0;
      dataCpuD    = '0;
      dataValidD  = '0;
      for (int k = 0; k < INSERTS; k++) begin
         dup = 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++)
            if (i < int'(count_q) && mem_q[wrapIdx(int'(head_q), i)] == bus.cpu_req_i[k])
               dup = 1'b1;
         for (int j = 0; j < k; j++)
            if (accepted[j] && bus.cpu_req_i[j] == bus.cpu_req_i[k])
               dup = 1'b1;
         accepted[k] = bus.take_req_i[k] & ~bus.lock_i & ~bus.flush_i & ~dup;
         nAcc        = nAcc + int'(accepted[k]);
      end
      cntAfterPop = int'(count_q) - (pop ? 1 : 0);
      freeSlots   = QUEUE_DEPTH - cntAfterPop;
      excess      = (nAcc > freeSlots) ? nAcc - freeSlots : 0;
      evict       = (DROP_OLDEST != 0) ? excess : 0;
      stored      = nAcc - ((DROP_OLDEST != 0) ? 0 : excess);
      // Tail writes may land on slots being popped or evicted in the same cycle.
      for (int k = 0; k < INSERTS; k++) begin
         if (accepted[k] && slot < stored) begin
            memD[wrapIdx(int'(head_q) + int'(count_q), slot)] = bus.cpu_req_i[k];
            slot = slot + 1;
         end
      end
      dropSum = {1'b0, dropCnt_q} + DW'(excess);
      if (bus.flush_i) begin
         headD  = '0;
         countD = '0;
      end else begin
         headD     = wrapIdx(int'(head_q), (pop ? 1 : 0) + evict);
         countD    = CW'(cntAfterPop - evict + stored);
         overflowD = (excess > 0);
         dropCntD  = dropSum[CNT_WIDTH] ? '1 : dropSum[CNT_WIDTH-1:0];
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         dataCpuD[i]   = memD[wrapIdx(int'(headD), i)];
         dataValidD[i] = (i < int'(countD));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         dropCnt_q   <= '0;
         dataValid_q <= '0;
      end else begin
         head_q      <= headD;
         count_q     <= countD;
         overflow_q  <= overflowD;
         dropCnt_q   <= dropCntD;
         dataValid_q <= dataValidD;
      end
   end

   // Payload storage needs no reset; validity is tracked by count and the valid vector.
   always_ff @(posedge clk_i) begin
      mem_q     <= memD;
      dataCpu_q <= dataCpuD;
   end

   assign bus.issue_valid_o = (count_q != '0);
   assign bus.issue_addr_o  = mem_q[head_q];
   assign bus.data_cpu_o    = dataCpu_q;
   assign bus.data_valid_o  = dataValid_q;
   assign bus.count_o       = count_q;
   assign bus.overflow_o    = overflow_q;
   assign bus.drop_cnt_o    = dropCnt_q;
endmodule

// File: tb/tb_hwpf_req_queue.sv
// Randomized scoreboard bench for hwpf_req_queue: two instances (evict-oldest and
// discard-new) share one stimulus stream and are compared against a queue-based model.
module tb_hwpf_req_queue;
   localparam int AW   = 40;
   localparam int D    = 3;
   localparam int INS  = 2;
   localparam int CNTW = 4;
   localparam int CW   = $clog2(D + 1);
   localparam int SAT  = (1 << CNTW) - 1;

   typedef logic [AW-1:0] addrq_t [$];
   typedef struct packed {
      logic [D-1:0][AW-1:0] data;
      logic [D-1:0]         valid;
      logic [CW-1:0]        count;
      logic                 issueValid;
      logic [AW-1:0]        issueAddr;
      logic                 overflow;
      logic [CNTW-1:0]      dropCnt;
   } snap_t;

   logic   clk = 1'b0;
   logic   rstN = 1'b0;
   int     assertCount = 0;
   int     failCount = 0;
   addrq_t qA, qB;
   int     dropA = 0, dropB = 0;
   bit     ovA = 1'b0, ovB = 1'b0;
   snap_t  expA [$];
   snap_t  expB [$];

   hwpf_req_queue_if #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(D), .INSERTS(INS), .CNT_WIDTH(CNTW)) busA ();
   hwpf_req_queue_if #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(D), .INSERTS(INS), .CNT_WIDTH(CNTW)) busB ();

   hwpf_req_queue #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(D), .INSERTS(INS), .DROP_OLDEST(1), .CNT_WIDTH(CNTW))
      dutA (.clk_i(clk), .rst_ni(rstN), .bus(busA.slave));
   hwpf_req_queue #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(D), .INSERTS(INS), .DROP_OLDEST(0), .CNT_WIDTH(CNTW))
      dutB (.clk_i(clk), .rst_ni(rstN), .bus(busB.slave));

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   function automatic logic [AW-1:0] mkAddr(input int x);
      return AW'(40'hCAFE0000 + AW'(x));
   endfunction

   // Reference model: queue semantics taken straight from the behavioural rules
   task automatic modelStep(input addrq_t qin, input int dropIn, input bit dropOldest,
                            input bit rst, input bit flush, input bit lock, input bit ready,
                            input logic [INS-1:0] take, input logic [INS-1:0][AW-1:0] addr,
                            output addrq_t qout, output int dropOut, output bit ovOut);
      addrq_t q;
      addrq_t acc;
      int     freeSlots, excess, n;
      bit     found;
      q = qin;
      acc = {};
      dropOut = dropIn;
      ovOut = 1'b0;
      if (!rst) begin
         q = {};
         dropOut = 0;
      end else if (flush) begin
         q = {};
      end else begin
         for (int k = 0; k < INS; k++) begin
            if (take[k] && !lock) begin
               found = 1'b0;
               foreach (q[i]) if (q[i] == addr[k]) found = 1'b1;
               foreach (acc[i]) if (acc[i] == addr[k]) found = 1'b1;
               if (!found) acc.push_back(addr[k]);
            end
         end
         if (q.size() != 0 && ready) void'(q.pop_front());
         n = acc.size();
         freeSlots = D - q.size();
         excess = (n > freeSlots) ? n - freeSlots : 0;
         if (dropOldest) begin
            repeat (excess) void'(q.pop_front());
            foreach (acc[i]) q.push_back(acc[i]);
         end else begin
            for (int i = 0; i < n - excess; i++) q.push_back(acc[i]);
         end
         dropOut = (dropIn + excess > SAT) ? SAT : dropIn + excess;
         ovOut = (excess > 0);
      end
      qout = q;
   endtask

   function automatic snap_t makeSnap(input addrq_t q, input int drop, input bit ov);
      snap_t s;
      s = '0;
      foreach (q[i]) begin
         s.data[i]  = q[i];
         s.valid[i] = 1'b1;
      end
      s.count      = CW'(q.size());
      s.issueValid = (q.size() != 0);
      s.issueAddr  = (q.size() != 0) ? q[0] : '0;
      s.overflow   = ov;
      s.dropCnt    = CNTW'(drop);
      return s;
   endfunction

   task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input snap_t act, input snap_t exp);
      compareField({tag, ".count"}, 64'(act.count), 64'(exp.count));
      compareField({tag, ".valid"}, 64'(act.valid), 64'(exp.valid));
      compareField({tag, ".issueValid"}, 64'(act.issueValid), 64'(exp.issueValid));
      compareField({tag, ".overflow"}, 64'(act.overflow), 64'(exp.overflow));
      compareField({tag, ".dropCnt"}, 64'(act.dropCnt), 64'(exp.dropCnt));
      if (exp.issueValid)
         compareField({tag, ".issueAddr"}, 64'(act.issueAddr), 64'(exp.issueAddr));
      for (int i = 0; i < D; i++)
         if (exp.valid[i])
            compareField($sformatf("%s.data[%0d]", tag, i), 64'(act.data[i]), 64'(exp.data[i]));
   endtask

   // Drive one cycle of inputs; record the state expected right now, then advance the model
   task automatic applyStimulus(input bit rst, input bit flush, input bit lock, input bit ready,
                                input logic [INS-1:0] take, input int a0, input int a1);
      logic [INS-1:0][AW-1:0] addr;
      addrq_t nq;
      int     nd;
      bit     nov;
      @(posedge clk);
      #1;
      expA.push_back(makeSnap(qA, dropA, ovA));
      expB.push_back(makeSnap(qB, dropB, ovB));
      addr[0] = mkAddr(a0);
      addr[1] = mkAddr(a1);
      rstN = rst;
      busA.flush_i = flush;        busB.flush_i = flush;
      busA.lock_i = lock;          busB.lock_i = lock;
      busA.issue_ready_i = ready;  busB.issue_ready_i = ready;
      busA.take_req_i = take;      busB.take_req_i = take;
      busA.cpu_req_i = addr;       busB.cpu_req_i = addr;
      modelStep(qA, dropA, 1'b1, rst, flush, lock, ready, take, addr, nq, nd, nov);
      qA = nq; dropA = nd; ovA = nov;
      modelStep(qB, dropB, 1'b0, rst, flush, lock, ready, take, addr, nq, nd, nov);
      qB = nq; dropB = nd; ovB = nov;
   endtask

   // Monitor: compares each recorded expectation against the DUTs mid-cycle
   initial begin
      snap_t act;
      forever begin
         @(posedge clk);
         #3;
         if (expA.size() != 0) begin
            act = {busA.data_cpu_o, busA.data_valid_o, busA.count_o, busA.issue_valid_o,
                   busA.issue_addr_o, busA.overflow_o, busA.drop_cnt_o};
            checkOutput("A", act, expA.pop_front());
         end
         if (expB.size() != 0) begin
            act = {busB.data_cpu_o, busB.data_valid_o, busB.count_o, busB.issue_valid_o,
                   busB.issue_addr_o, busB.overflow_o, busB.drop_cnt_o};
            checkOutput("B", act, expB.pop_front());
         end
      end
   end

   initial begin
      busA.flush_i = 0; busA.lock_i = 0; busA.issue_ready_i = 0; busA.take_req_i = '0; busA.cpu_req_i = '0;
      busB.flush_i = 0; busB.lock_i = 0; busB.issue_ready_i = 0; busB.take_req_i = '0; busB.cpu_req_i = '0;
      $display("[TB] directed sequence");
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus(1, 0, 1, 0, 2'b01, 0, 0);
      applyStimulus(1, 0, 0, 0, 2'b01, 0, 0);
      applyStimulus(1, 0, 0, 0, 2'b11, 1, 1);
      applyStimulus(1, 0, 0, 0, 2'b11, 0, 1);
      applyStimulus(1, 0, 0, 0, 2'b01, 2, 0);
      applyStimulus(1, 0, 0, 0, 2'b11, 3, 4);
      applyStimulus(1, 0, 0, 1, 2'b01, 3, 0);
      applyStimulus(1, 1, 0, 1, 2'b01, 5, 0);
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 0, 0, 0, 2'b01, 8 + i, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 0, 0, 1, 2'b00, 0, 0);
      $display("[TB] randomized sequence");
      for (int i = 0; i < 600; i++)
         applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)));
      applyStimulus(1, 0, 0, 0, 2'b00, 0, 0);
      repeat (3) @(posedge clk);
      #4;
      compareField("scoreboardDrained", 64'(expA.size() + expB.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
